// File: rtl/bus_transfer_ctrl_if.sv
// Command handshake and register-bus control bundle for bus_transfer_ctrl.
// master = command issuer / bus observer, slave = the controller.
interface bus_transfer_ctrl_if #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
);
    logic                req_valid;
    logic                req_ready;
    logic                req_imm;
    logic [IDX_W-1:0]    req_src;
    logic [IDX_W-1:0]    req_dst;
    logic [7:0]          req_data;
    logic [NUM_REGS-1:0] reg_oe;
    logic [NUM_REGS-1:0] reg_ld;
    logic                imm_oe;
    logic [7:0]          imm_data;
    logic                busy;
    logic                done;
    logic                err;
    logic [IDX_W+1:0]    q_level;

    modport master (
        output req_valid, req_imm, req_src, req_dst, req_data,
        input  req_ready, reg_oe, reg_ld, imm_oe, imm_data, busy, done, err, q_level
    );

    modport slave (
        input  req_valid, req_imm, req_src, req_dst, req_data,
        output req_ready, reg_oe, reg_ld, imm_oe, imm_data, busy, done, err, q_level
    );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Sequences moves on the shared 8-bit tri-state register bus: drive, settle, load.
// Optional command FIFO enabled by defining BUS_CTRL_QUEUE_EN.
//
// state | meaning
// IDLE  | no enables; waiting for (or popping) a command
// DRIVE | source enable on, bus settling, no load
// LOAD  | source enable held, dst load strobe high
module bus_transfer_ctrl #(
    parameter int NUM_REGS    = 4,
    parameter int IDX_W       = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    bus_transfer_ctrl_if.slave bus
);
    localparam int Q_AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int Q_CW = Q_AW + 1;
    localparam logic [IDX_W:0] NUM_LIM = (IDX_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, LOAD = 2'd2} state_t;

    typedef struct packed {
        logic             imm;
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
        logic [7:0]       data;
    } cmd_t;

    state_t           state;
    cmd_t             cur;
    logic             push;
    logic             take;
    logic             cur_legal;
    logic             start;
    logic [Q_CW-1:0]  count;
    logic [Q_CW-1:0]  count_nxt;
    logic [IDX_W-1:0] dst_q;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_REGS'(1) << idx;
    endfunction

    assign push = bus.req_valid && bus.req_ready;

`ifdef BUS_CTRL_QUEUE_EN
    cmd_t            fifo_mem [QUEUE_DEPTH];
    logic [Q_AW-1:0] wr_ptr;
    logic [Q_AW-1:0] rd_ptr;
    logic            pop;

    assign pop           = (state == IDLE) && (count != '0);
    assign take          = pop;
    assign cur           = fifo_mem[rd_ptr];
    assign bus.req_ready = (count != Q_CW'(QUEUE_DEPTH));
    assign count_nxt     = count + Q_CW'(push) - Q_CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{imm: bus.req_imm, src: bus.req_src,
                                  dst: bus.req_dst, data: bus.req_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + Q_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + Q_AW'(1);
            count <= count_nxt;
        end
    end
`else
    assign take          = push;
    assign cur           = '{imm: bus.req_imm, src: bus.req_src,
                             dst: bus.req_dst, data: bus.req_data};
    assign bus.req_ready = (state == IDLE) && !rst;
    assign count         = '0;
    assign count_nxt     = '0;
`endif

    // The source index is meaningless for immediates, so only reg moves check it.
    assign cur_legal = !((!cur.imm && (cur.src == cur.dst)) ||
                         (!cur.imm && ({1'b0, cur.src} >= NUM_LIM)) ||
                         ({1'b0, cur.dst} >= NUM_LIM));
    assign start     = take && cur_legal;
    assign bus.q_level = (IDX_W+2)'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.reg_oe   <= '0;
            bus.reg_ld   <= '0;
            bus.imm_oe   <= 1'b0;
            bus.imm_data <= 8'h00;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.busy     <= 1'b0;
            dst_q        <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            bus.busy <= start || (state == DRIVE) || (count_nxt != '0);
            case (state)
                IDLE: begin
                    if (take) begin
                        if (cur_legal) begin
                            state <= DRIVE;
                            dst_q <= cur.dst;
                            if (cur.imm) begin
                                bus.imm_oe   <= 1'b1;
                                bus.imm_data <= cur.data;
                            end else begin
                                bus.reg_oe <= onehot(cur.src);
                            end
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    state      <= LOAD;
                    bus.reg_ld <= onehot(dst_q);
                end
                LOAD: begin
                    state      <= IDLE;
                    bus.reg_oe <= '0;
                    bus.reg_ld <= '0;
                    bus.imm_oe <= 1'b0;
                    bus.done   <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    bus.reg_oe <= '0;
                    bus.reg_ld <= '0;
                    bus.imm_oe <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Randomized bench for bus_transfer_ctrl against a per-cycle timeline model of
// each command's drive/load/done window; models the register file on the bus too.
module tb_bus_transfer_ctrl;
    localparam int NUM_REGS    = 4;
    localparam int IDX_W       = 3;
    localparam int QUEUE_DEPTH = 4;
    localparam int MAXC        = 1100;
`ifdef BUS_CTRL_QUEUE_EN
    localparam bit QMODE = 1'b1;
`else
    localparam bit QMODE = 1'b0;
`endif

    typedef struct packed {
        logic             imm;
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
        logic [7:0]       data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_transfer_ctrl_if #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) bus ();

    bus_transfer_ctrl #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .QUEUE_DEPTH(QUEUE_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // register file sitting on the bus
    logic [7:0] env_regs [NUM_REGS] = '{8'h11, 8'h3C, 8'h55, 8'h77};
    logic [7:0] mdl_regs [NUM_REGS] = '{8'h11, 8'h3C, 8'h55, 8'h77};
    logic [7:0] bus_val;

    always_comb begin
        bus_val = 8'h00;
        if (bus.imm_oe) bus_val = bus.imm_data;
        for (int i = 0; i < NUM_REGS; i++)
            if (bus.reg_oe[i]) bus_val = env_regs[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++)
            if (bus.reg_ld[i]) env_regs[i] <= bus_val;
    end

    logic [NUM_REGS-1:0] exp_oe       [MAXC];
    logic [NUM_REGS-1:0] exp_ld       [MAXC];
    bit                  exp_imm_oe   [MAXC];
    logic [7:0]          exp_imm_data [MAXC];
    bit                  exp_done     [MAXC];
    bit                  exp_err      [MAXC];
    bit                  exp_act      [MAXC];
    int                  pop_sched    [MAXC];
    cmd_t                stim_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic bit legal(input cmd_t c);
        return !((!c.imm && c.src == c.dst) || (!c.imm && int'(c.src) >= NUM_REGS) ||
                 int'(c.dst) >= NUM_REGS);
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.imm  = 1'($urandom_range(0, 1));
        c.data = 8'($urandom);
        c.src  = IDX_W'($urandom_range(0, NUM_REGS - 1));
        if (!c.imm && $urandom_range(0, 9) == 0) c.src = IDX_W'($urandom_range(NUM_REGS, 7));
        c.dst  = IDX_W'($urandom_range(0, NUM_REGS - 1));
        if ($urandom_range(0, 9) == 0) c.dst = IDX_W'($urandom_range(NUM_REGS, 7));
        return c;
    endfunction

    // Commit one command taken (popped or accepted) in cycle p; returns the first cycle
    // in which the controller can take another.
    function automatic int schedule(input int p, input cmd_t c);
        if (p + 3 >= MAXC) return p + 3;
        if (legal(c)) begin
            for (int t = p + 1; t <= p + 2; t++) begin
                exp_act[t] = 1'b1;
                if (c.imm) begin
                    exp_imm_oe[t]   = 1'b1;
                    exp_imm_data[t] = c.data;
                end else begin
                    exp_oe[t] = NUM_REGS'(1) << c.src;
                end
            end
            exp_ld[p + 2]   = NUM_REGS'(1) << c.dst;
            exp_done[p + 3] = 1'b1;
            mdl_regs[c.dst[1:0]] = c.imm ? c.data : mdl_regs[c.src[1:0]];
            return p + 3;
        end
        exp_err[p + 1] = 1'b1;
        return p + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        #3;
        chk("rst_async_oe", bus.reg_oe, 0);
        chk("rst_async_ld", bus.reg_ld, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_oe", bus.reg_oe, 0);
        chk("rst_ld", bus.reg_ld, 0);
        chk("rst_imm_oe", bus.imm_oe, 0);
        chk("rst_imm_data", bus.imm_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_q_level", bus.q_level, 0);
    endtask

    task automatic run_phase(input int n_rand, input int p_valid, input int max_cyc);
        int   c, free, occ, p, drivers;
        bit   presenting, ready_c, push;
        cmd_t cur;
        for (int i = 0; i < MAXC; i++) begin
            exp_oe[i] = '0; exp_ld[i] = '0; exp_imm_oe[i] = 1'b0; exp_imm_data[i] = 8'h00;
            exp_done[i] = 1'b0; exp_err[i] = 1'b0; exp_act[i] = 1'b0; pop_sched[i] = 0;
        end
        for (int i = 0; i < n_rand; i++) stim_q.push_back(rand_cmd());
        c = 0; free = 0; occ = 0; presenting = 1'b0; cur = '0;
        while (c < max_cyc && (stim_q.size() != 0 || presenting || c <= free + 1)) begin
            @(posedge clk);
            #1;
            if (!presenting && stim_q.size() != 0 && $urandom_range(1, 100) <= p_valid) begin
                cur = stim_q.pop_front();
                presenting = 1'b1;
            end
            bus.req_valid = presenting;
            bus.req_imm   = presenting ? cur.imm  : 1'($urandom);
            bus.req_src   = presenting ? cur.src  : IDX_W'($urandom);
            bus.req_dst   = presenting ? cur.dst  : IDX_W'($urandom);
            bus.req_data  = presenting ? cur.data : 8'($urandom);
            @(negedge clk);
            chk("reg_oe", bus.reg_oe, exp_oe[c]);
            chk("reg_ld", bus.reg_ld, exp_ld[c]);
            chk("imm_oe", bus.imm_oe, exp_imm_oe[c]);
            if (exp_imm_oe[c]) chk("imm_data", bus.imm_data, exp_imm_data[c]);
            chk("done", bus.done, exp_done[c]);
            chk("err", bus.err, exp_err[c]);
            chk("busy", bus.busy, exp_act[c] || (QMODE && occ != 0));
            chk("q_level", bus.q_level, QMODE ? occ : 0);
            drivers = $countones(bus.reg_oe) + int'(bus.imm_oe);
            chk("one_driver", drivers <= 1, 1);
            chk("ld_onehot", $countones(bus.reg_ld) <= 1, 1);
            chk("ld_without_src", (bus.reg_ld != 0) && (drivers == 0), 0);
            ready_c = QMODE ? (occ < QUEUE_DEPTH) : (c >= free);
            chk("req_ready", bus.req_ready, ready_c);
            push = presenting && ready_c;
            if (push) begin
                if (QMODE) begin
                    p = (c + 1 > free) ? c + 1 : free;
                    if (p < MAXC) pop_sched[p]++;
                end else begin
                    p = c;
                end
                free = schedule(p, cur);
                presenting = 1'b0;
            end
            if (QMODE) occ = occ + int'(push) - pop_sched[c];
            c++;
        end
        bus.req_valid = 1'b0;
        chk("phase_drained", c < max_cyc, 1);
        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("reg%0d_value", i), env_regs[i], mdl_regs[i]);
    endtask

    task automatic reset_mid_load();
        int ld_cyc;
        ld_cyc = QMODE ? 3 : 2;
        for (int c = 0; c <= ld_cyc; c++) begin
            @(posedge clk);
            #1;
            bus.req_valid = (c == 0);
            bus.req_imm   = 1'b0;
            bus.req_src   = IDX_W'(1);
            bus.req_dst   = IDX_W'(3);
            bus.req_data  = 8'h00;
            @(negedge clk);
        end
        chk("mid_pre_ld", bus.reg_ld, 4'b1000);
        chk("mid_pre_oe", bus.reg_oe, 4'b0010);
        rst = 1'b1;
        #1;
        chk("mid_rst_ld", bus.reg_ld, 0);
        chk("mid_rst_oe", bus.reg_oe, 0);
        chk("mid_rst_imm_oe", bus.imm_oe, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_busy", bus.busy, 0);
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_err", bus.err, 0);
            chk("post_rst_ld", bus.reg_ld, 0);
        end
        chk("mid_rst_dst_kept", env_regs[3], mdl_regs[3]);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_imm   = 1'b0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_data  = 8'h00;
        do_reset();
        stim_q.push_back('{imm: 1'b0, src: 3'd1, dst: 3'd3, data: 8'h00});
        stim_q.push_back('{imm: 1'b1, src: 3'd0, dst: 3'd2, data: 8'hA5});
        stim_q.push_back('{imm: 1'b0, src: 3'd2, dst: 3'd2, data: 8'h00});
        stim_q.push_back('{imm: 1'b0, src: 3'd0, dst: 3'd5, data: 8'h00});
        stim_q.push_back('{imm: 1'b1, src: 3'd1, dst: 3'd0, data: 8'h5A});
        run_phase(16, 100, 400);
        do_reset();
        run_phase(60, 45, 900);
        do_reset();
        reset_mid_load();
        run_phase(12, 70, 300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
